// File: rtl/bp_nonsynth_pkg.sv
// rtl/bp_nonsynth_pkg.sv - shared types and constants for the retire aligner
// Purpose: retire-queue entry layout, head FSM state encoding, instruction field offsets.
// The entry layout uses the default PC/instruction widths; the aligner's
// vaddr_width_p/instr_width_p must match vaddr_width_gp/instr_width_gp.
package bp_nonsynth_pkg;

    localparam int unsigned vaddr_width_gp    = 39;
    localparam int unsigned instr_width_gp    = 32;
    localparam int unsigned reg_addr_width_gp = 5;
    localparam int unsigned rd_offset_lp      = 7;

    typedef struct packed {
        logic                      trap;
        logic [vaddr_width_gp-1:0] pc;
        logic [instr_width_gp-1:0] instr;
        logic                      iwb;
        logic                      fwb;
    } bp_nonsynth_retire_entry_s;

    typedef enum logic [1:0] {
        e_empty = 2'd0,
        e_wait  = 2'd1,
        e_ready = 2'd2
    } bp_nonsynth_retire_state_e;

endpackage

// File: rtl/bp_nonsynth_retire_aligner_if.sv
// rtl/bp_nonsynth_retire_aligner_if.sv - commit/writeback/retire bundle for the retire aligner
// Purpose: groups the commit stream, integer and FP writeback streams, the retire
// record handshake and the sticky error flags.
// Modports: master = core + trace consumer side, slave = aligner side.
interface bp_nonsynth_retire_aligner_if #(
    parameter int vaddr_width_p = 39,
    parameter int instr_width_p = 32,
    parameter int data_width_p  = 64
);
    logic                     commit_v_i;
    logic                     commit_trap_i;
    logic [vaddr_width_p-1:0] commit_pc_i;
    logic [instr_width_p-1:0] commit_instr_i;
    logic                     commit_iwb_i;
    logic                     commit_fwb_i;

    logic                     ird_w_v_i;
    logic [4:0]               ird_addr_i;
    logic [data_width_p-1:0]  ird_data_i;
    logic                     frd_w_v_i;
    logic [4:0]               frd_addr_i;
    logic [data_width_p-1:0]  frd_data_i;

    logic                     retire_v_o;
    logic                     retire_yumi_i;
    logic [vaddr_width_p-1:0] retire_pc_o;
    logic [instr_width_p-1:0] retire_instr_o;
    logic                     retire_trap_o;
    logic                     retire_rd_w_v_o;
    logic                     retire_fp_o;
    logic [data_width_p-1:0]  retire_data_o;

    logic                     overrun_o;
    logic                     wb_conflict_o;
    logic                     timeout_o;

    modport master (
        output commit_v_i, commit_trap_i, commit_pc_i, commit_instr_i, commit_iwb_i, commit_fwb_i,
        output ird_w_v_i, ird_addr_i, ird_data_i, frd_w_v_i, frd_addr_i, frd_data_i,
        output retire_yumi_i,
        input  retire_v_o, retire_pc_o, retire_instr_o, retire_trap_o, retire_rd_w_v_o,
        input  retire_fp_o, retire_data_o, overrun_o, wb_conflict_o, timeout_o
    );

    modport slave (
        input  commit_v_i, commit_trap_i, commit_pc_i, commit_instr_i, commit_iwb_i, commit_fwb_i,
        input  ird_w_v_i, ird_addr_i, ird_data_i, frd_w_v_i, frd_addr_i, frd_data_i,
        input  retire_yumi_i,
        output retire_v_o, retire_pc_o, retire_instr_o, retire_trap_o, retire_rd_w_v_o,
        output retire_fp_o, retire_data_o, overrun_o, wb_conflict_o, timeout_o
    );

endinterface

// File: rtl/bsg_fifo_1r1w_small.sv
// rtl/bsg_fifo_1r1w_small.sv - small register-based FIFO used as the commit queue
// Purpose: 2^lg_els_p entry FIFO, head visible combinationally on data_o.
// Ports: clk_i/reset_i (sync, active-high); v_i/ready_o/data_i enqueue side;
// v_o/data_o/yumi_i dequeue side. ready_o includes a same-cycle dequeue, so a
// full FIFO can accept an entry in the cycle its head is consumed.
module bsg_fifo_1r1w_small #(
    parameter int width_p  = 8,
    parameter int lg_els_p = 3
)(
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int els_lp = 1 << lg_els_p;
    localparam logic [lg_els_p:0] full_count_lp = (lg_els_p + 1)'(els_lp);

    logic [width_p-1:0]  mem_q [els_lp];
    logic [lg_els_p-1:0] rptr_q, wptr_q;
    logic [lg_els_p:0]   count_q;
    logic                full, enq, deq;

    assign full    = (count_q == full_count_lp);
    assign v_o     = (count_q != '0);
    assign ready_o = ~full | yumi_i;
    assign data_o  = mem_q[rptr_q];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq) wptr_q <= wptr_q + 1'b1;
            if (deq) rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + (lg_els_p + 1)'(enq) - (lg_els_p + 1)'(deq);
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/bp_nonsynth_retire_aligner.sv
// rtl/bp_nonsynth_retire_aligner.sv - pairs in-order commits with out-of-order RF writebacks
// Purpose: queues committed instructions, captures integer/FP writeback data in
// per-register slots and presents in-order retire records with their data.
// Ports: clk_i, reset_i (sync, active-high); io (slave modport) carries the commit
// stream, integer/FP writebacks, retire record + yumi, and sticky overrun /
// wb_conflict / timeout flags.
module bp_nonsynth_retire_aligner
    import bp_nonsynth_pkg::*;
#(
    parameter int vaddr_width_p = 39,
    parameter int instr_width_p = 32,
    parameter int data_width_p  = 64,
    parameter int lg_depth_p    = 3,
    parameter int timeout_p     = 1024
)(
    input  logic                        clk_i,
    input  logic                        reset_i,
    bp_nonsynth_retire_aligner_if.slave io
);
    localparam int cnt_width_lp = $clog2(timeout_p + 1);
    localparam logic [cnt_width_lp-1:0] timeout_lp = cnt_width_lp'(timeout_p);
    localparam int entry_width_lp = $bits(bp_nonsynth_retire_entry_s);

    // Commit queue
    bp_nonsynth_retire_entry_s enq_entry, head_entry;
    logic fifo_ready, fifo_v, fifo_deq;

    always_comb begin
        enq_entry       = '0;
        enq_entry.trap  = io.commit_trap_i;
        enq_entry.pc    = io.commit_pc_i;
        enq_entry.instr = io.commit_instr_i;
        enq_entry.iwb   = io.commit_iwb_i;
        enq_entry.fwb   = io.commit_fwb_i;
    end

    bsg_fifo_1r1w_small #(
        .width_p  (entry_width_lp),
        .lg_els_p (lg_depth_p)
    ) commit_queue (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (io.commit_v_i),
        .ready_o (fifo_ready),
        .data_i  (enq_entry),
        .v_o     (fifo_v),
        .data_o  (head_entry),
        .yumi_i  (fifo_deq)
    );

    // Data slots
    logic [31:0]             ivalid_q, ivalid_d, fvalid_q, fvalid_d;
    logic [data_width_p-1:0] idata_q [32];
    logic [data_width_p-1:0] fdata_q [32];

    // Head decode
    logic [4:0]              head_rd;
    logic                    head_fp, head_needs, slot_v, retire_v;
    logic [data_width_p-1:0] slot_data;

    assign head_rd = head_entry.instr[rd_offset_lp +: reg_addr_width_gp];
    // iwb+fwb together is illegal; the FP file takes precedence.
    assign head_fp = head_entry.fwb;
    // x0 is never written, so an integer write to x0 carries no data.
    assign head_needs = ~head_entry.trap
                      & (head_entry.fwb | (head_entry.iwb & (head_rd != 5'd0)));
    assign slot_v    = head_fp ? fvalid_q[head_rd] : ivalid_q[head_rd];
    assign slot_data = head_fp ? fdata_q[head_rd]  : idata_q[head_rd];
    assign retire_v  = fifo_v & (~head_needs | slot_v);
    assign fifo_deq  = io.retire_yumi_i & retire_v;

    // Slot bookkeeping
    logic iwb_en, fwb_en, free_i, free_f, i_conflict, f_conflict, overrun;

    assign iwb_en = io.ird_w_v_i & (io.ird_addr_i != 5'd0);
    assign fwb_en = io.frd_w_v_i;
    assign free_i = fifo_deq & head_needs & ~head_fp;
    assign free_f = fifo_deq & head_needs &  head_fp;

    // A slot being freed this cycle may be refilled without it counting as a conflict.
    assign i_conflict = iwb_en & ivalid_q[io.ird_addr_i] & ~(free_i & (head_rd == io.ird_addr_i));
    assign f_conflict = fwb_en & fvalid_q[io.frd_addr_i] & ~(free_f & (head_rd == io.frd_addr_i));
    assign overrun    = io.commit_v_i & ~fifo_ready;

    always_comb begin
        ivalid_d = ivalid_q;
        fvalid_d = fvalid_q;
        // Clear before set so a same-cycle refill keeps the slot valid.
        if (free_i) ivalid_d[head_rd] = 1'b0;
        if (free_f) fvalid_d[head_rd] = 1'b0;
        if (iwb_en) ivalid_d[io.ird_addr_i] = 1'b1;
        if (fwb_en) fvalid_d[io.frd_addr_i] = 1'b1;
    end

    logic overrun_q, conflict_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ivalid_q   <= '0;
            fvalid_q   <= '0;
            overrun_q  <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            ivalid_q <= ivalid_d;
            fvalid_q <= fvalid_d;
            if (overrun)                 overrun_q  <= 1'b1;
            if (i_conflict | f_conflict) conflict_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (iwb_en) idata_q[io.ird_addr_i] <= io.ird_data_i;
        if (fwb_en) fdata_q[io.frd_addr_i] <= io.frd_data_i;
    end

    // Head FSM with wait counter. The FSM follows the head one cycle behind; after
    // a yumi it passes through e_empty, which classifies the new head next cycle.
    bp_nonsynth_retire_state_e state_q;
    logic [cnt_width_lp-1:0]   wait_cnt_q;
    logic                      timeout_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= e_empty;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            case (state_q)
                e_empty: begin
                    if (fifo_v) state_q <= retire_v ? e_ready : e_wait;
                    wait_cnt_q <= '0;
                end
                e_wait: begin
                    if (retire_v) begin
                        state_q    <= e_ready;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q != timeout_lp) begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                    if (wait_cnt_q == timeout_lp) timeout_q <= 1'b1;
                end
                e_ready: begin
                    if (fifo_deq) state_q <= e_empty;
                    wait_cnt_q <= '0;
                end
                default: begin
                    state_q    <= e_empty;
                    wait_cnt_q <= '0;
                end
            endcase
        end
    end

    // Retire record: combinational from head and slot, zero while not valid.
    always_comb begin
        io.retire_v_o      = retire_v;
        io.retire_pc_o     = '0;
        io.retire_instr_o  = '0;
        io.retire_trap_o   = 1'b0;
        io.retire_rd_w_v_o = 1'b0;
        io.retire_fp_o     = 1'b0;
        io.retire_data_o   = '0;
        if (retire_v) begin
            io.retire_pc_o     = vaddr_width_p'(head_entry.pc);
            io.retire_instr_o  = instr_width_p'(head_entry.instr);
            io.retire_trap_o   = head_entry.trap;
            io.retire_rd_w_v_o = head_needs;
            io.retire_fp_o     = head_needs & head_fp;
            io.retire_data_o   = head_needs ? slot_data : '0;
        end
    end

    assign io.overrun_o     = overrun_q;
    assign io.wb_conflict_o = conflict_q;
    assign io.timeout_o     = timeout_q;

endmodule

// File: tb/tb_bp_nonsynth_retire_aligner.sv
// tb/tb_bp_nonsynth_retire_aligner.sv - directed scoreboard bench for bp_nonsynth_retire_aligner
module tb_bp_nonsynth_retire_aligner;

    localparam int timeout_lp = 1024;

    typedef struct {
        logic [38:0] pc;
        logic [31:0] instr;
        logic        trap;
        logic        rdv;
        logic        fp;
        logic [63:0] data;
    } exp_s;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    exp_s sb[$];

    bp_nonsynth_retire_aligner_if #(.vaddr_width_p(39), .instr_width_p(32), .data_width_p(64)) io ();

    bp_nonsynth_retire_aligner #(
        .vaddr_width_p (39),
        .instr_width_p (32),
        .data_width_p  (64),
        .lg_depth_p    (3),
        .timeout_p     (timeout_lp)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .io      (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and drop all one-cycle pulses.
    task automatic step();
        @(negedge clk);
        io.commit_v_i    = 1'b0;
        io.ird_w_v_i     = 1'b0;
        io.frd_w_v_i     = 1'b0;
        io.retire_yumi_i = 1'b0;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb.delete();
    endtask

    function automatic logic [31:0] mk_instr(input logic [4:0] rd, input logic fp);
        logic [31:0] w;
        if (fp) w = {7'b1111001, 5'd0, 5'd10, 3'b000, rd, 7'h53};
        else    w = {12'h001, 5'd0, 3'b000, rd, 7'h13};
        return w;
    endfunction

    task automatic commit(input logic trap, input logic [38:0] pc, input logic [4:0] rd,
                          input logic iwb, input logic fwb, input logic exp_rdv,
                          input logic [63:0] exp_data, input logic keep);
        exp_s e;
        io.commit_v_i     = 1'b1;
        io.commit_trap_i  = trap;
        io.commit_pc_i    = pc;
        io.commit_instr_i = trap ? 32'h0000_0073 : mk_instr(rd, fwb);
        io.commit_iwb_i   = iwb;
        io.commit_fwb_i   = fwb;
        if (keep) begin
            e.pc    = pc;
            e.instr = io.commit_instr_i;
            e.trap  = trap;
            e.rdv   = exp_rdv;
            e.fp    = exp_rdv & fwb;
            e.data  = exp_rdv ? exp_data : 64'd0;
            sb.push_back(e);
        end
    endtask

    task automatic wb_int(input logic [4:0] a, input logic [63:0] d);
        io.ird_w_v_i = 1'b1; io.ird_addr_i = a; io.ird_data_i = d;
    endtask

    task automatic wb_fp(input logic [4:0] a, input logic [63:0] d);
        io.frd_w_v_i = 1'b1; io.frd_addr_i = a; io.frd_data_i = d;
    endtask

    // Wait (bounded) for a record, compare it against the scoreboard head, accept it.
    task automatic expect_retire(input string tag, input int max_wait);
        exp_s e;
        int   n = 0;
        while (io.retire_v_o !== 1'b1 && n < max_wait) begin
            step();
            n++;
        end
        check({tag, "_v"}, 64'(io.retire_v_o), 64'd1);
        if (io.retire_v_o === 1'b1) begin
            check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check({tag, "_pc"},    64'(io.retire_pc_o),     64'(e.pc));
                check({tag, "_instr"}, 64'(io.retire_instr_o),  64'(e.instr));
                check({tag, "_trap"},  64'(io.retire_trap_o),   64'(e.trap));
                check({tag, "_rdv"},   64'(io.retire_rd_w_v_o), 64'(e.rdv));
                check({tag, "_fp"},    64'(io.retire_fp_o),     64'(e.fp));
                check({tag, "_data"},  io.retire_data_o,        e.data);
            end
            io.retire_yumi_i = 1'b1;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        io.commit_v_i = 1'b0; io.commit_trap_i = 1'b0; io.commit_pc_i = '0;
        io.commit_instr_i = '0; io.commit_iwb_i = 1'b0; io.commit_fwb_i = 1'b0;
        io.ird_w_v_i = 1'b0; io.ird_addr_i = '0; io.ird_data_i = '0;
        io.frd_w_v_i = 1'b0; io.frd_addr_i = '0; io.frd_data_i = '0;
        io.retire_yumi_i = 1'b0;
        do_reset();

        // Reset state
        check("rst_v",        64'(io.retire_v_o),    64'd0);
        check("rst_overrun",  64'(io.overrun_o),     64'd0);
        check("rst_conflict", 64'(io.wb_conflict_o), 64'd0);
        check("rst_timeout",  64'(io.timeout_o),     64'd0);
        check("rst_data",     io.retire_data_o,      64'd0);
        check("rst_pc",       64'(io.retire_pc_o),   64'd0);

        // Integer commit waits for late writeback
        step(); commit(1'b0, 39'h1000, 5'd5, 1'b1, 1'b0, 1'b1, 64'h1234, 1'b1);
        step();
        step(); check("x5_wait_c2", 64'(io.retire_v_o), 64'd0);
        step(); check("x5_wait_c3", 64'(io.retire_v_o), 64'd0);
        wb_int(5'd5, 64'h1234);
        step(); expect_retire("x5", 0);
        step(); commit(1'b0, 39'h1004, 5'd5, 1'b1, 1'b0, 1'b1, 64'h55, 1'b1);
        step();
        step(); check("x5_freed", 64'(io.retire_v_o), 64'd0);
        wb_int(5'd5, 64'h55);
        step(); expect_retire("x5_again", 0);

        // FP data present before commit: one-cycle latency
        step(); wb_fp(5'd2, 64'h3FF0_0000_0000_0000);
        step(); commit(1'b0, 39'h2000, 5'd2, 1'b0, 1'b1, 1'b1, 64'h3FF0_0000_0000_0000, 1'b1);
        step(); expect_retire("f2", 0);

        // Nine commits into an eight-deep queue
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step();
            commit(i[0], 39'h3000 + 39'(4 * i), 5'd0, ~i[0], 1'b0, 1'b0, 64'd0, i < 8);
        end
        step(); check("ovr_set", 64'(io.overrun_o), 64'd1);
        for (int i = 0; i < 8; i++) begin
            expect_retire($sformatf("ovr_rec%0d", i), 2);
            step();
        end
        check("ovr_ninth_dropped", 64'(io.retire_v_o), 64'd0);

        // Full queue accepts a commit in the same cycle as a retire
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step();
            commit(1'b1, 39'h4000 + 39'(4 * i), 5'd0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
        end
        step(); expect_retire("full_bypass0", 0);
        commit(1'b1, 39'h4100, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
        step(); check("full_bypass_no_ovr", 64'(io.overrun_o), 64'd0);
        for (int i = 1; i < 9; i++) begin
            expect_retire($sformatf("full_rec%0d", i), 2);
            step();
        end

        // Free and refill x7 in one cycle is not a conflict
        do_reset();
        step(); wb_int(5'd7, 64'hC0C0);
        commit(1'b0, 39'h5000, 5'd7, 1'b1, 1'b0, 1'b1, 64'hC0C0, 1'b1);
        step(); expect_retire("x7_free", 0);
        wb_int(5'd7, 64'hD0D0);
        step(); check("x7_refill_no_conflict", 64'(io.wb_conflict_o), 64'd0);
        commit(1'b0, 39'h5004, 5'd7, 1'b1, 1'b0, 1'b1, 64'hD0D0, 1'b1);
        step(); expect_retire("x7_refilled", 0);

        // Double writeback to x7 before its commit
        step(); wb_int(5'd7, 64'hAAAA);
        step(); check("x7_first_no_conflict", 64'(io.wb_conflict_o), 64'd0);
        wb_int(5'd7, 64'hBBBB);
        step(); check("x7_conflict", 64'(io.wb_conflict_o), 64'd1);
        commit(1'b0, 39'h5008, 5'd7, 1'b1, 1'b0, 1'b1, 64'hBBBB, 1'b1);
        step(); expect_retire("x7_second_value", 0);

        // Trap and x0 commit retire without waiting
        do_reset();
        step(); commit(1'b1, 39'h6000, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
        step(); commit(1'b0, 39'h6004, 5'd0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
        expect_retire("trap", 0);
        step(); expect_retire("x0", 0);
        step(); check("x0_drained", 64'(io.retire_v_o), 64'd0);

        // Head starved on x9 until timeout
        do_reset();
        step(); commit(1'b0, 39'h7000, 5'd9, 1'b1, 1'b0, 1'b1, 64'h9999, 1'b1);
        for (int i = 0; i < timeout_lp - 2; i++) step();
        check("to_not_yet", 64'(io.timeout_o), 64'd0);
        for (int i = 0; i < 6; i++) step();
        check("to_set", 64'(io.timeout_o), 64'd1);
        check("to_head_blocked", 64'(io.retire_v_o), 64'd0);
        wb_int(5'd9, 64'h9999);
        step(); expect_retire("to_late_wb", 0);
        step(); check("to_sticky", 64'(io.timeout_o), 64'd1);

        // Reset while waiting discards the head and clears the flag
        commit(1'b0, 39'h7004, 5'd9, 1'b1, 1'b0, 1'b1, 64'h0, 1'b0);
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        step(); reset = 1'b0;
        check("rst_mid_v", 64'(io.retire_v_o), 64'd0);
        check("rst_mid_timeout", 64'(io.timeout_o), 64'd0);
        wb_int(5'd9, 64'h1111);
        step();
        step(); check("rst_mid_discarded", 64'(io.retire_v_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
